weather_sensor_conditioner: RTL and testbench
=============================================

Name: weather_sensor_conditioner

Overview:
Upstream stage of ECSU. Takes raw, asynchronous-rate weather sensor samples (wind, temperature, visibility, thunderstorm) and filters and qualifies them into the stable per-signal values ECSU consumes. It also runs a sensor-loss watchdog that forces worst-case weather when samples stop arriving, which drives ECSU to severe weather.

Parameters:
AVG_LOG2, 2, log2 of the moving-average window depth for wind and temperature (window = 4 samples)
TS_DEBOUNCE, 3, number of consecutive qualifying samples needed to change thunderstorm or to lower visibility
TIMEOUT_CYCLES, 1000, number of CLK cycles without sample_valid before sensor_fault asserts (1 ms at 1 MHz)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-low reset
sample_valid  input  1  one-cycle strobe; raw_* inputs valid this cycle
raw_wind  input  6  raw wind speed, unsigned
raw_temperature  input  8  raw temperature, signed two's complement
raw_visibility  input  2  raw visibility code; 0 = best, 3 = worst
raw_thunderstorm  input  1  raw thunderstorm detect
wind  output  6  averaged wind, to ECSU
temperature  output  8  averaged signed temperature, to ECSU
visibility  output  2  qualified visibility, to ECSU
thunderstorm  output  1  debounced thunderstorm, to ECSU
data_valid  output  1  one-cycle pulse when outputs were updated
sensor_fault  output  1  sample watchdog expired

Behaviour:
- Reset (RST low, async): all outputs 0. Buffers, sums, debounce counters, watchdog counter and write pointer cleared. The primed flag is cleared.
- Latency: outputs update on the edge after the sample_valid cycle. data_valid is high for exactly that one cycle. No backpressure; every sample_valid is accepted.
- Averaging (wind, temperature): circular buffer of 2^AVG_LOG2 entries.
  - Running sums: wind is unsigned, 6+AVG_LOG2 bits. Temperature is signed, 8+AVG_LOG2 bits.
  - First sample after reset or after fault clear (primed = 0) preloads every entry. Sum = sample << AVG_LOG2. Set primed.
  - Otherwise: sum <= sum − entry[ptr] + sample; entry[ptr] <= sample; ptr wraps modulo depth.
  - Output = sum >> AVG_LOG2. Temperature uses an arithmetic shift, i.e. floor toward −infinity. No saturation is needed; the result always fits the output width.
- Thunderstorm debounce: counter of consecutive samples whose raw value differs from the current output.
  - A sample equal to the output clears the counter.
  - When the counter reaches TS_DEBOUNCE: output toggles and the counter clears.
- Visibility (fast-worse, slow-better):
  - raw > out: out = raw immediately; counter clears.
  - raw == out: counter clears.
  - raw < out: if raw == candidate, counter++; else candidate = raw, counter = 1.
  - When the counter reaches TS_DEBOUNCE: out = candidate; counter clears.
- Watchdog: counts CLK cycles since the last accepted sample; saturates at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES: sensor_fault = 1, thunderstorm = 1, visibility = 3, and data_valid pulses once. Wind and temperature hold their values.
  - While in fault, data_valid stays 0.
  - If sample_valid arrives in the same cycle the count would reach TIMEOUT_CYCLES, the sample wins: counter clears and no fault is raised.
- Fault clear: the next sample_valid clears sensor_fault and re-primes the averaging window with that sample.
  - thunderstorm and visibility keep their forced values and re-qualify through the normal debounce rules, so safe values hold for at least TS_DEBOUNCE samples.
- Reset mid-operation: immediate return to reset values. No partial update completes.

Optional Feature:
SENSOR_RANGE_CHECK_EN
- Defined:
  - A sample with raw_wind == 6'h3F or raw_temperature == 8'h80 (sensor error codes) is rejected. A rejected sample leaves buffers, debounce and outputs unchanged, does not clear the watchdog, and produces no data_valid.
  - An extra output port sample_rejected (1 bit) pulses for one cycle, one cycle after the rejected strobe.
- Undefined: all samples are accepted and the sample_rejected port does not exist.

Test Plan:
1. Reset, then sample wind=12, temp=−20, vis=0, ts=0 → next cycle: wind=12, temperature=−20, data_valid=1 for exactly 1 cycle.
2. After priming with wind=12, send wind 16, 20, 20 → wind outputs 13, 15, 17. Prime temp=−36, then send −37 → temperature = −37 (floor of −145/4).
3. raw_thunderstorm sequence 1, 1, 0, 1, 1, 1 → thunderstorm rises only after the 6th sample. Then 0, 0, 0 → falls after the 3rd.
4. raw_visibility 0 then 3 → visibility = 3 after one sample. Then 1, 2, 1, 1, 1 → stays 3 until the final 1, then becomes 1.
5. No sample_valid for 1000 cycles → sensor_fault=1, thunderstorm=1, visibility=3, one data_valid pulse. Repeat with a sample at cycle 999 → no fault. A sample after fault → sensor_fault=0, wind/temp re-primed to that sample, thunderstorm still 1.
6. Pull RST low mid-stream with wind=20, ts=1 → all outputs 0 asynchronously. The first sample after release primes the window.

Source files
------------

// File: rtl/weather_sensor_conditioner.sv
// Conditions raw weather samples into stable wind/temperature/visibility/thunderstorm values
// and forces worst-case weather on sensor loss. Optional feature macro: SENSOR_RANGE_CHECK_EN.
module weather_sensor_conditioner #(
  parameter int AVG_LOG2       = 2,
  parameter int TS_DEBOUNCE    = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       sample_valid,
  input  logic [5:0] raw_wind,
  input  logic [7:0] raw_temperature,
  input  logic [1:0] raw_visibility,
  input  logic       raw_thunderstorm,
  output logic [5:0] wind,
  output logic [7:0] temperature,
  output logic [1:0] visibility,
  output logic       thunderstorm,
  output logic       data_valid,
  output logic       sensor_fault
`ifdef SENSOR_RANGE_CHECK_EN
  ,
  output logic       sample_rejected
`endif
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int WSUM_W = 6 + AVG_LOG2;
  localparam int TSUM_W = 8 + AVG_LOG2;
  localparam int DB_W   = $clog2(TS_DEBOUNCE + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DB_W-1:0]     DB_ONE   = DB_W'(1);
  localparam logic [DB_W-1:0]     DB_LIMIT = DB_W'(TS_DEBOUNCE);
  localparam logic [WD_W-1:0]     WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]     WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [AVG_LOG2-1:0] PTR_ONE  = AVG_LOG2'(1);

  logic [5:0]          wind_buf [DEPTH];
  logic [7:0]          temp_buf [DEPTH];
  logic [AVG_LOG2-1:0] ptr;
  logic [WSUM_W-1:0]   wind_sum;
  logic [TSUM_W-1:0]   temp_sum;
  logic                primed;
  logic [DB_W-1:0]     ts_cnt;
  logic [DB_W-1:0]     vis_cnt;
  logic [1:0]          vis_cand;
  logic [WD_W-1:0]     wd_cnt;

  logic                accept;
  logic                wd_expire;
  logic [WSUM_W-1:0]   wind_sum_next;
  logic [TSUM_W-1:0]   temp_sum_next;
  logic                ts_next;
  logic [DB_W-1:0]     ts_cnt_next;
  logic [1:0]          vis_next;
  logic [1:0]          vis_cand_next;
  logic [DB_W-1:0]     vis_cnt_next;
  logic [DB_W-1:0]     vis_step;

`ifdef SENSOR_RANGE_CHECK_EN
  // All-ones wind and most-negative temperature are the sensor's error codes.
  logic range_err;
  assign range_err = (raw_wind == 6'h3F) || (raw_temperature == 8'h80);
  assign accept    = sample_valid && !range_err;
`else
  assign accept    = sample_valid;
`endif

  assign wd_expire = !accept && !sensor_fault && ((wd_cnt + WD_ONE) == WD_LIMIT);

  // Running sums; an unprimed window is preloaded so the first output equals the sample.
  always_comb begin
    wind_sum_next = '0;
    temp_sum_next = '0;
    if (primed) begin
      wind_sum_next = wind_sum - {{AVG_LOG2{1'b0}}, wind_buf[ptr]}
                               + {{AVG_LOG2{1'b0}}, raw_wind};
      temp_sum_next = temp_sum - {{AVG_LOG2{temp_buf[ptr][7]}}, temp_buf[ptr]}
                               + {{AVG_LOG2{raw_temperature[7]}}, raw_temperature};
    end else begin
      wind_sum_next = {raw_wind, {AVG_LOG2{1'b0}}};
      temp_sum_next = {raw_temperature, {AVG_LOG2{1'b0}}};
    end
  end

  always_comb begin
    ts_next     = thunderstorm;
    ts_cnt_next = '0;
    if (raw_thunderstorm != thunderstorm) begin
      if ((ts_cnt + DB_ONE) == DB_LIMIT) ts_next = ~thunderstorm;
      else                               ts_cnt_next = ts_cnt + DB_ONE;
    end
  end

  // Visibility worsens at once but only improves after a stable run of one better code.
  always_comb begin
    vis_next      = visibility;
    vis_cand_next = vis_cand;
    vis_cnt_next  = '0;
    vis_step      = '0;
    if (raw_visibility > visibility) begin
      vis_next = raw_visibility;
    end else if (raw_visibility < visibility) begin
      if (raw_visibility == vis_cand) begin
        vis_step = vis_cnt + DB_ONE;
      end else begin
        vis_cand_next = raw_visibility;
        vis_step      = DB_ONE;
      end
      if (vis_step == DB_LIMIT) vis_next     = vis_cand_next;
      else                      vis_cnt_next = vis_step;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        wind_buf[i] <= '0;
        temp_buf[i] <= '0;
      end
      ptr          <= '0;
      wind_sum     <= '0;
      temp_sum     <= '0;
      primed       <= 1'b0;
      ts_cnt       <= '0;
      vis_cnt      <= '0;
      vis_cand     <= '0;
      wd_cnt       <= '0;
      wind         <= '0;
      temperature  <= '0;
      visibility   <= '0;
      thunderstorm <= 1'b0;
      data_valid   <= 1'b0;
      sensor_fault <= 1'b0;
`ifdef SENSOR_RANGE_CHECK_EN
      sample_rejected <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
`ifdef SENSOR_RANGE_CHECK_EN
      sample_rejected <= sample_valid && range_err;
`endif
      if (accept) begin
        if (primed) begin
          wind_buf[ptr] <= raw_wind;
          temp_buf[ptr] <= raw_temperature;
          ptr           <= ptr + PTR_ONE;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            wind_buf[i] <= raw_wind;
            temp_buf[i] <= raw_temperature;
          end
        end
        wind_sum     <= wind_sum_next;
        temp_sum     <= temp_sum_next;
        primed       <= 1'b1;
        // Taking the upper bits of a two's-complement sum is a floor division.
        wind         <= wind_sum_next[AVG_LOG2 +: 6];
        temperature  <= temp_sum_next[AVG_LOG2 +: 8];
        thunderstorm <= ts_next;
        ts_cnt       <= ts_cnt_next;
        visibility   <= vis_next;
        vis_cand     <= vis_cand_next;
        vis_cnt      <= vis_cnt_next;
        wd_cnt       <= '0;
        sensor_fault <= 1'b0;
        data_valid   <= 1'b1;
      end else if (wd_expire) begin
        sensor_fault <= 1'b1;
        thunderstorm <= 1'b1;
        visibility   <= 2'b11;
        ts_cnt       <= '0;
        vis_cnt      <= '0;
        primed       <= 1'b0;
        wd_cnt       <= WD_LIMIT;
        data_valid   <= 1'b1;
      end else if (wd_cnt != WD_LIMIT) begin
        wd_cnt <= wd_cnt + WD_ONE;
      end
    end
  end

endmodule

// File: tb/tb_weather_sensor_conditioner.sv
// Scoreboard bench for weather_sensor_conditioner: expected outputs are queued with each
// sample (or expected fault) and compared whenever data_valid pulses.
module tb_weather_sensor_conditioner;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       sample_valid = 1'b0;
  logic [5:0] raw_wind = '0;
  logic [7:0] raw_temperature = '0;
  logic [1:0] raw_visibility = '0;
  logic       raw_thunderstorm = 1'b0;
  logic [5:0] wind;
  logic [7:0] temperature;
  logic [1:0] visibility;
  logic       thunderstorm;
  logic       data_valid;
  logic       sensor_fault;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int wind;
    int temp;
    int vis;
    int ts;
    int fault;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  weather_sensor_conditioner dut (
    .CLK              (CLK),
    .RST              (RST),
    .sample_valid     (sample_valid),
    .raw_wind         (raw_wind),
    .raw_temperature  (raw_temperature),
    .raw_visibility   (raw_visibility),
    .raw_thunderstorm (raw_thunderstorm),
    .wind             (wind),
    .temperature      (temperature),
    .visibility       (visibility),
    .thunderstorm     (thunderstorm),
    .data_valid       (data_valid),
    .sensor_fault     (sensor_fault)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drives one sample strobe and queues the outputs it should produce; returns one negedge later.
  task automatic applyStimulus(input int w, input int t, input int v, input int s,
                               input int ew, input int et, input int ev, input int es,
                               input int ef);
    exp_t e;
    @(negedge CLK);
    raw_wind         = w[5:0];
    raw_temperature  = t[7:0];
    raw_visibility   = v[1:0];
    raw_thunderstorm = s[0];
    sample_valid     = 1'b1;
    e.wind = ew; e.temp = et; e.vis = ev; e.ts = es; e.fault = ef;
    exp_q.push_back(e);
    @(negedge CLK);
    sample_valid = 1'b0;
  endtask

  task automatic sendSample(input int w, input int t, input int v, input int s,
                            input int ew, input int et, input int ev, input int es,
                            input int ef);
    applyStimulus(w, t, v, s, ew, et, ev, es, ef);
    repeat (2) @(negedge CLK);
    checkOutput("drain", exp_q.size(), 0);
  endtask

  always @(negedge CLK) begin
    if (RST && data_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_dv", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wind", int'(wind), mon_e.wind);
        checkOutput("temperature", int'($signed(temperature)), mon_e.temp);
        checkOutput("visibility", int'(visibility), mon_e.vis);
        checkOutput("thunderstorm", int'(thunderstorm), mon_e.ts);
        checkOutput("sensor_fault", int'(sensor_fault), mon_e.fault);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    int ts_seq [9]  = '{1, 1, 0, 1, 1, 1, 0, 0, 0};
    int ts_exp [9]  = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
    int vis_seq [7] = '{0, 3, 1, 2, 1, 1, 1};
    int vis_exp [7] = '{0, 3, 3, 3, 3, 3, 1};

    repeat (3) @(negedge CLK);
    checkOutput("rst_wind", int'(wind), 0);
    checkOutput("rst_temp", int'(temperature), 0);
    checkOutput("rst_vis", int'(visibility), 0);
    checkOutput("rst_ts", int'(thunderstorm), 0);
    checkOutput("rst_dv", int'(data_valid), 0);
    checkOutput("rst_fault", int'(sensor_fault), 0);
    RST = 1'b1;

    // First sample primes the window and produces exactly one data_valid pulse.
    applyStimulus(12, -20, 0, 0, 12, -20, 0, 0, 0);
    checkOutput("dv_high", int'(data_valid), 1);
    @(negedge CLK);
    checkOutput("dv_low", int'(data_valid), 0);
    @(negedge CLK);
    checkOutput("drain", exp_q.size(), 0);

    sendSample(16, -20, 0, 0, 13, -20, 0, 0, 0);
    sendSample(20, -20, 0, 0, 15, -20, 0, 0, 0);
    sendSample(20, -20, 0, 0, 17, -20, 0, 0, 0);

    // Negative averaging rounds toward minus infinity.
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK); RST = 1'b1;
    sendSample(0, -36, 0, 0, 0, -36, 0, 0, 0);
    sendSample(0, -37, 0, 0, 0, -37, 0, 0, 0);
    sendSample(0, 10, 0, 0, 0, -25, 0, 0, 0);
    sendSample(0, 10, 0, 0, 0, -14, 0, 0, 0);

    for (int i = 0; i < 9; i++)
      sendSample(0, 10, 0, ts_seq[i], 0, (i == 0) ? -2 : 10, 0, ts_exp[i], 0);

    for (int i = 0; i < 7; i++)
      sendSample(0, 10, vis_seq[i], 0, 0, 10, vis_exp[i], 0, 0);

    // A sample landing on the cycle the watchdog would expire keeps the fault away.
    applyStimulus(8, 10, 1, 0, 2, 10, 1, 0, 0);
    repeat (998) @(negedge CLK);
    checkOutput("wd_pre", int'(sensor_fault), 0);
    applyStimulus(8, 10, 1, 0, 4, 10, 1, 0, 0);
    checkOutput("wd_sample_wins", int'(sensor_fault), 0);

    // Silence for the full timeout raises the fault exactly on the limit cycle.
    repeat (999) @(negedge CLK);
    checkOutput("wd_before_limit", int'(sensor_fault), 0);
    begin
      exp_t e;
      e.wind = 4; e.temp = 10; e.vis = 3; e.ts = 1; e.fault = 1;
      exp_q.push_back(e);
    end
    @(negedge CLK);
    checkOutput("wd_fault", int'(sensor_fault), 1);
    repeat (20) @(negedge CLK);
    checkOutput("fault_single_pulse", exp_q.size(), 0);
    checkOutput("fault_held", int'(sensor_fault), 1);

    // Recovery re-primes the averages; safe weather holds for a full debounce run.
    sendSample(20, -5, 0, 0, 20, -5, 3, 1, 0);
    sendSample(20, -5, 0, 0, 20, -5, 3, 1, 0);
    sendSample(20, -5, 0, 0, 20, -5, 0, 0, 0);

    sendSample(20, -5, 0, 1, 20, -5, 0, 0, 0);
    sendSample(20, -5, 0, 1, 20, -5, 0, 0, 0);
    sendSample(20, -5, 0, 1, 20, -5, 0, 1, 0);

    // Asynchronous reset between clock edges clears outputs immediately.
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("async_wind", int'(wind), 0);
    checkOutput("async_temp", int'(temperature), 0);
    checkOutput("async_vis", int'(visibility), 0);
    checkOutput("async_ts", int'(thunderstorm), 0);
    checkOutput("async_dv", int'(data_valid), 0);
    checkOutput("async_fault", int'(sensor_fault), 0);
    @(negedge CLK);
    RST = 1'b1;
    sendSample(40, 7, 0, 0, 40, 7, 0, 0, 0);
    sendSample(0, 7, 0, 0, 30, 7, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
